latch_monitor: RTL and testbench
================================

// Module: latch_monitor
// PURPOSE
//  Downstream consumer of the SR/JK/D latch block. Brings the six asynchronous latch outputs into the clk domain.
//  Per latch channel: detects edges, counts transitions and flags complementary-output violations (q == qn).
//  Feeds the status/debug register file; all outputs are synchronous to clk.
// PARAMETERS
//  SYNC_STAGES  2   synchronizer depth per input bit (legal >= 2)
//  CNT_W        8   width of each per-channel transition counter
//  INV_CYCLES   3   consecutive synced cycles with q == qn required to raise a violation
//  FILT_CYCLES  4   stability window, used only when LATCH_MON_GLITCH_FILTER_EN is defined
// PORTS
//  clk        in   1        system clock, rising edge
//  rst_n      in   1        asynchronous active-low reset
//  sr_q/sr_qn in   1 each   SR latch outputs (async)
//  jk_q/jk_qn in   1 each   JK latch outputs (async)
//  d_q/d_qn   in   1 each   D latch outputs (async)
//  clr        in   1        sync clear of counters and sticky flags
//  rise       out  3        1-cycle pulse on q 0->1; bit0=SR, bit1=JK, bit2=D
//  fall       out  3        1-cycle pulse on q 1->0; same bit order
//  inv_flag   out  3        sticky violation flag per channel
//  sr_cnt     out  CNT_W    SR q transition count
//  jk_cnt     out  CNT_W    JK q transition count
//  d_cnt      out  CNT_W    D q transition count
// BEHAVIOUR
//  - Reset (rst_n=0, async): all sync flops, rise, fall, inv_flag, counters, violation run-counters -> 0.
//  - Sync: each of the 6 inputs passes SYNC_STAGES flops; s_q/s_qn = last stage.
//  - Edge: prev_q registered from s_q. rise = s_q & ~prev_q; fall = ~s_q & prev_q.
//  - Latency: input change to rise/fall pulse = SYNC_STAGES+1 clk edges.
//  - Post-reset mask: rise/fall/counting/violation suppressed for the first SYNC_STAGES+1 cycles after rst_n deasserts.
//    No spurious edge is reported from reset values.
//  - Counter: +1 on each rise or fall; saturates at 2^CNT_W-1 and holds (no wrap).
//  - Violation: run counter increments while s_q == s_qn, else resets to 0.
//    Run counter saturates at INV_CYCLES. inv_flag[i] sets when the run reaches INV_CYCLES and holds until clr or reset.
//  - clr: in the cycle it is sampled, counters and inv_flag clear to 0. Counter = 0 even if an edge occurs that cycle.
//    inv_flag = 0 even if a violation completes that cycle; a still-ongoing violation re-flags after INV_CYCLES more cycles.
//  - rise/fall pulses are not affected by clr.
//  - Channels are independent; simultaneous events on all three are handled in the same cycle.
//  - Reset mid-operation: immediate async clear; the mask window restarts on deassertion.
// CONFIGURATION
//  LATCH_MON_GLITCH_FILTER_EN defined:
//    - Per-bit filtered value updates only after s_q (resp. s_qn) has held a new value for FILT_CYCLES consecutive cycles.
//    - Edges, counts and violations use the filtered values. Latency becomes SYNC_STAGES+FILT_CYCLES+1.
//    - Pulses shorter than FILT_CYCLES are ignored. Filtered values reset to 0.
//  Not defined: filtered value = s_q/s_qn directly; no filter logic is instantiated.
// STRUCTURE
//  - Package latch_mon_pkg: channel index constants CH_SR=0, CH_JK=1, CH_D=2; NUM_CH=3; default CNT_W.
//  - Sub-module latch_mon_chan (one instance per channel): synchronizers, optional filter, edge detect, counter, violation logic.
//  - Top level: post-reset mask counter, three latch_mon_chan instances, output packing.
// TESTING
//  1 Reset: hold rst_n=0 with sr_q=1 -> release. No rise pulse in any cycle; sr_cnt stays 0; inv_flag=000.
//  2 Edge/latency: sr_q 0->1, sr_qn 1->0 after mask -> rise[0] high exactly 1 cycle, 3 edges later; sr_cnt=1.
//    Return to 0 -> fall[0] pulse; sr_cnt=2.
//  3 SR invalid: sr_q=sr_qn=0 for 2 cycles then restore -> inv_flag[0]=0.
//    Hold 3 cycles -> inv_flag[0]=1 and it remains 1 after restore.
//  4 JK toggle burst: 260 jk_q transitions spaced 4 cycles -> jk_cnt=255 (saturated); rise/fall still pulse.
//  5 clr collision: assert clr the same cycle a d_q edge reaches the counter -> d_cnt=0 next cycle; inv_flag cleared.
//  6 Filter (macro on, FILT_CYCLES=4): 2-cycle d_q glitch -> no pulse, d_cnt=0.
//    6-cycle pulse -> rise and fall each once; d_cnt=2.

Source files
------------

// File: rtl/latch_mon_pkg.sv
// Shared constants for latch_monitor: channel indices, default widths, mask length.
// Build option: define LATCH_MON_GLITCH_FILTER_EN to enable the per-bit glitch filter.
package latch_mon_pkg;

  localparam int CH_SR         = 0;
  localparam int CH_JK         = 1;
  localparam int CH_D          = 2;
  localparam int NUM_CH        = 3;
  localparam int DEFAULT_CNT_W = 8;

`ifdef LATCH_MON_GLITCH_FILTER_EN
  localparam bit FILTER_EN = 1'b1;
`else
  localparam bit FILTER_EN = 1'b0;
`endif

  // Cycles after reset release until synced (and filtered) values reflect the real inputs.
  function automatic int mask_len(input int sync_stages, input int filt_cycles);
    return sync_stages + 1 + (FILTER_EN ? filt_cycles : 0);
  endfunction

endpackage

// File: rtl/latch_mon_chan.sv
// One latch channel: q/qn synchronizers, optional glitch filter, edge detect,
// saturating transition counter and sticky q==qn violation flag (LATCH_MON_GLITCH_FILTER_EN).
module latch_mon_chan #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8,
  parameter int INV_CYCLES  = 3
`ifdef LATCH_MON_GLITCH_FILTER_EN
  ,
  parameter int FILT_CYCLES = 4
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_q,
  input  logic             i_qn,
  input  logic             i_clr,
  input  logic             i_en,
  output logic             o_rise,
  output logic             o_fall,
  output logic             o_inv_flag,
  output logic [CNT_W-1:0] o_cnt
);

  localparam int               RUN_W   = $clog2(INV_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(INV_CYCLES);

  logic [SYNC_STAGES-1:0] r_sync_q;
  logic [SYNC_STAGES-1:0] r_sync_qn;
  logic                   w_s_q;
  logic                   w_s_qn;
  logic                   w_f_q;
  logic                   w_f_qn;
  logic                   r_prev_q;
  logic                   r_rise;
  logic                   r_fall;
  logic                   r_inv_flag;
  logic [CNT_W-1:0]       r_cnt;
  logic [RUN_W-1:0]       r_run;
  logic [RUN_W-1:0]       w_run_nxt;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_equal;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_q  <= '0;
      r_sync_qn <= '0;
    end else begin
      r_sync_q  <= {r_sync_q[SYNC_STAGES-2:0], i_q};
      r_sync_qn <= {r_sync_qn[SYNC_STAGES-2:0], i_qn};
    end
  end

  assign w_s_q  = r_sync_q[SYNC_STAGES-1];
  assign w_s_qn = r_sync_qn[SYNC_STAGES-1];

`ifdef LATCH_MON_GLITCH_FILTER_EN
  localparam int STAB_W = $clog2(FILT_CYCLES + 1);

  logic [1:0] w_raw;
  logic [1:0] w_filt;

  assign w_raw = {w_s_qn, w_s_q};

  for (genvar b = 0; b < 2; b++) begin : g_filt
    logic              r_val;
    logic [STAB_W-1:0] r_stab;

    // r_stab counts consecutive cycles the synced bit has differed from the accepted value.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_val  <= 1'b0;
        r_stab <= '0;
      end else if (w_raw[b] == r_val) begin
        r_stab <= '0;
      end else if (r_stab == STAB_W'(FILT_CYCLES - 1)) begin
        r_val  <= w_raw[b];
        r_stab <= '0;
      end else begin
        r_stab <= r_stab + 1'b1;
      end
    end

    assign w_filt[b] = r_val;
  end

  assign w_f_q  = w_filt[0];
  assign w_f_qn = w_filt[1];
`else
  assign w_f_q  = w_s_q;
  assign w_f_qn = w_s_qn;
`endif

  assign w_rise  = w_f_q & ~r_prev_q;
  assign w_fall  = ~w_f_q & r_prev_q;
  assign w_equal = (w_f_q == w_f_qn);

  // NOTE: default assignment first keeps this purely combinational (no inferred latch).
  always_comb begin
    w_run_nxt = '0;
    if (i_en && w_equal) begin
      w_run_nxt = (r_run == RUN_MAX) ? RUN_MAX : r_run + 1'b1;
    end
  end

  // clr wins over a coincident edge or completing violation; pulses ignore clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_q   <= 1'b0;
      r_rise     <= 1'b0;
      r_fall     <= 1'b0;
      r_cnt      <= '0;
      r_run      <= '0;
      r_inv_flag <= 1'b0;
    end else begin
      r_prev_q <= w_f_q;
      r_rise   <= w_rise & i_en;
      r_fall   <= w_fall & i_en;
      if (i_clr) begin
        r_cnt      <= '0;
        r_run      <= '0;
        r_inv_flag <= 1'b0;
      end else begin
        if (i_en && (w_rise || w_fall) && (r_cnt != CNT_MAX)) begin
          r_cnt <= r_cnt + 1'b1;
        end
        r_run <= w_run_nxt;
        if (w_run_nxt == RUN_MAX) begin
          r_inv_flag <= 1'b1;
        end
      end
    end
  end

  assign o_rise     = r_rise;
  assign o_fall     = r_fall;
  assign o_inv_flag = r_inv_flag;
  assign o_cnt      = r_cnt;

endmodule

// File: rtl/latch_monitor.sv
// Brings SR/JK/D latch outputs into the clk domain and reports edges, counts, q==qn violations.
// Build option: LATCH_MON_GLITCH_FILTER_EN adds a FILT_CYCLES stability filter per input bit.
module latch_monitor
  import latch_mon_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = DEFAULT_CNT_W,
  parameter int INV_CYCLES  = 3,
  parameter int FILT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sr_q,
  input  logic              sr_qn,
  input  logic              jk_q,
  input  logic              jk_qn,
  input  logic              d_q,
  input  logic              d_qn,
  input  logic              clr,
  output logic [NUM_CH-1:0] rise,
  output logic [NUM_CH-1:0] fall,
  output logic [NUM_CH-1:0] inv_flag,
  output logic [CNT_W-1:0]  sr_cnt,
  output logic [CNT_W-1:0]  jk_cnt,
  output logic [CNT_W-1:0]  d_cnt
);

  localparam int MASK_CYCLES = mask_len(SYNC_STAGES, FILT_CYCLES);
  localparam int MASK_W      = $clog2(MASK_CYCLES + 1);

  logic [MASK_W-1:0] r_mask_cnt;
  logic              w_en;
  logic [NUM_CH-1:0] w_q;
  logic [NUM_CH-1:0] w_qn;
  logic [NUM_CH-1:0] w_rise;
  logic [NUM_CH-1:0] w_fall;
  logic [NUM_CH-1:0] w_inv;
  logic [CNT_W-1:0]  w_cnt [NUM_CH];

  // Reset values in the synchronizers are not real latch states; hold detection off until flushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask_cnt <= '0;
    end else if (!w_en) begin
      r_mask_cnt <= r_mask_cnt + 1'b1;
    end
  end

  assign w_en = (r_mask_cnt == MASK_W'(MASK_CYCLES));

  assign w_q[CH_SR]  = sr_q;
  assign w_q[CH_JK]  = jk_q;
  assign w_q[CH_D]   = d_q;
  assign w_qn[CH_SR] = sr_qn;
  assign w_qn[CH_JK] = jk_qn;
  assign w_qn[CH_D]  = d_qn;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    latch_mon_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W),
      .INV_CYCLES  (INV_CYCLES)
`ifdef LATCH_MON_GLITCH_FILTER_EN
      ,
      .FILT_CYCLES (FILT_CYCLES)
`endif
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_q        (w_q[c]),
      .i_qn       (w_qn[c]),
      .i_clr      (clr),
      .i_en       (w_en),
      .o_rise     (w_rise[c]),
      .o_fall     (w_fall[c]),
      .o_inv_flag (w_inv[c]),
      .o_cnt      (w_cnt[c])
    );
  end

  assign rise     = w_rise;
  assign fall     = w_fall;
  assign inv_flag = w_inv;
  assign sr_cnt   = w_cnt[CH_SR];
  assign jk_cnt   = w_cnt[CH_JK];
  assign d_cnt    = w_cnt[CH_D];

endmodule

// File: tb/tb_latch_monitor.sv
// Scoreboard bench for latch_monitor: stimulus queues expected pulses, a monitor pops and compares.
// Covers reset masking, latency, violations, saturation, clr collision and the glitch filter build.
`timescale 1ns/1ps
module tb_latch_monitor;
  import latch_mon_pkg::*;

`ifdef LATCH_MON_GLITCH_FILTER_EN
  localparam int FILT     = 4;
  localparam int LAT      = 2 + FILT + 1;
  localparam int INV_LONG = FILT;
`else
  localparam int LAT      = 3;
  localparam int INV_LONG = 3;
`endif
  localparam int SETTLE = LAT + 5;

  logic       clk;
  logic       rst_n;
  logic       sr_q, sr_qn, jk_q, jk_qn, d_q, d_qn;
  logic       clr;
  logic [2:0] rise, fall, inv_flag;
  logic [7:0] sr_cnt, jk_cnt, d_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int         cyc;
    logic [2:0] rise;
    logic [2:0] fall;
    int         ch;
    int         cnt;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  latch_monitor dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sr_q     (sr_q),
    .sr_qn    (sr_qn),
    .jk_q     (jk_q),
    .jk_qn    (jk_qn),
    .d_q      (d_q),
    .d_qn     (d_qn),
    .clr      (clr),
    .rise     (rise),
    .fall     (fall),
    .inv_flag (inv_flag),
    .sr_cnt   (sr_cnt),
    .jk_cnt   (jk_cnt),
    .d_cnt    (d_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int ch, input logic [2:0] r, input logic [2:0] f, input int cnt);
    exp_t e;
    e.cyc  = cyc + LAT;
    e.rise = r;
    e.fall = f;
    e.ch   = ch;
    e.cnt  = cnt;
    sb_q.push_back(e);
  endtask

  function automatic int cnt_of(input int ch);
    case (ch)
      CH_SR:   return int'(sr_cnt);
      CH_JK:   return int'(jk_cnt);
      default: return int'(d_cnt);
    endcase
  endfunction

  always @(negedge clk) begin
    if (rise != 3'b000 || fall != 3'b000) begin
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", int'({rise, fall}), 0);
      end else begin
        mon_e = sb_q.pop_front();
        check("pulse_cycle", cyc, mon_e.cyc);
        check("pulse_rise", int'(rise), int'(mon_e.rise));
        check("pulse_fall", int'(fall), int'(mon_e.fall));
        check("pulse_cnt", cnt_of(mon_e.ch), mon_e.cnt);
      end
    end else if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
      mon_e = sb_q.pop_front();
      check("missed_pulse", cyc, mon_e.cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    sr_q = 1'b1; sr_qn = 1'b0;
    jk_q = 1'b0; jk_qn = 1'b1;
    d_q  = 1'b0; d_qn  = 1'b1;
    clr  = 1'b0;
    rst_n = 1'b0;
    tick(3);
    check("rst_rise", int'(rise), 0);
    check("rst_fall", int'(fall), 0);
    check("rst_inv", int'(inv_flag), 0);
    check("rst_sr_cnt", int'(sr_cnt), 0);

    // sr_q held high through reset must not produce a rise
    rst_n = 1'b1;
    tick(SETTLE + 4);
    check("mask_sr_cnt", int'(sr_cnt), 0);
    check("mask_inv", int'(inv_flag), 0);

    // reset mid-operation, then start from sr_q=0
    rst_n = 1'b0;
    sr_q = 1'b0; sr_qn = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(SETTLE + 4);
    check("rerst_sr_cnt", int'(sr_cnt), 0);

    // edge latency and counting
    sr_q = 1'b1; sr_qn = 1'b0;
    push(CH_SR, 3'b001, 3'b000, 1);
    tick(SETTLE);
    check("sr_cnt_rise", int'(sr_cnt), 1);
    sr_q = 1'b0; sr_qn = 1'b1;
    push(CH_SR, 3'b000, 3'b001, 2);
    tick(SETTLE);
    check("sr_cnt_fall", int'(sr_cnt), 2);

    // SR violation: too short, then exactly long enough
    sr_qn = 1'b0;
    tick(2);
    sr_qn = 1'b1;
    tick(SETTLE);
    check("inv_short", int'(inv_flag), 0);
    sr_qn = 1'b0;
    tick(INV_LONG);
    sr_qn = 1'b1;
    tick(SETTLE);
    check("inv_set", int'(inv_flag), 3'b001);
    tick(5);
    check("inv_sticky", int'(inv_flag), 3'b001);

    // JK burst to saturation
    for (int k = 1; k <= 260; k++) begin
      jk_q  = ~jk_q;
      jk_qn = ~jk_q;
      push(CH_JK, {1'b0, jk_q, 1'b0}, {1'b0, ~jk_q, 1'b0}, (k > 255) ? 255 : k);
      tick(4);
    end
    tick(SETTLE);
    check("jk_sat", int'(jk_cnt), 255);
    check("sr_indep", int'(sr_cnt), 2);

    // clr sampled on the same edge the d_q rise reaches the counter
    d_q = 1'b1; d_qn = 1'b0;
    push(CH_D, 3'b100, 3'b000, 0);
    tick(LAT - 1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("clr_d_cnt", int'(d_cnt), 0);
    check("clr_inv", int'(inv_flag), 0);
    check("clr_jk_cnt", int'(jk_cnt), 0);
    check("clr_sr_cnt", int'(sr_cnt), 0);
    tick(SETTLE);
    check("clr_d_cnt_hold", int'(d_cnt), 0);

    // ongoing JK violation re-flags INV_CYCLES cycles after clr
    jk_qn = jk_q;
    tick(SETTLE);
    check("jk_inv_set", int'(inv_flag), 3'b010);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("jk_inv_clr", int'(inv_flag), 0);
    tick(2);
    check("jk_inv_wait", int'(inv_flag), 0);
    tick(1);
    check("jk_inv_reflag", int'(inv_flag), 3'b010);
    jk_qn = ~jk_q;
    tick(SETTLE);

    // return d_q low and clear before the pulse tests
    d_q = 1'b0; d_qn = 1'b1;
    push(CH_D, 3'b000, 3'b100, 1);
    tick(SETTLE);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("d_cnt_cleared", int'(d_cnt), 0);

`ifdef LATCH_MON_GLITCH_FILTER_EN
    d_q = 1'b1; d_qn = 1'b0;
    tick(2);
    d_q = 1'b0; d_qn = 1'b1;
    tick(SETTLE);
    check("glitch_d_cnt", int'(d_cnt), 0);
    d_q = 1'b1; d_qn = 1'b0;
    push(CH_D, 3'b100, 3'b000, 1);
    tick(6);
    d_q = 1'b0; d_qn = 1'b1;
    push(CH_D, 3'b000, 3'b100, 2);
    tick(SETTLE);
    check("pulse_d_cnt", int'(d_cnt), 2);
`else
    d_q = 1'b1; d_qn = 1'b0;
    push(CH_D, 3'b100, 3'b000, 1);
    tick(2);
    d_q = 1'b0; d_qn = 1'b1;
    push(CH_D, 3'b000, 3'b100, 2);
    tick(SETTLE);
    check("pulse_d_cnt", int'(d_cnt), 2);
`endif

    // simultaneous rise on all three channels
    sr_q = 1'b1; sr_qn = 1'b0;
    jk_q = 1'b1; jk_qn = 1'b0;
    d_q  = 1'b1; d_qn  = 1'b0;
    push(CH_SR, 3'b111, 3'b000, 1);
    tick(SETTLE);
    check("all_jk_cnt", int'(jk_cnt), 1);
    check("all_d_cnt", int'(d_cnt), 3);
    check("all_inv", int'(inv_flag), 0);

    tick(SETTLE);
    check("sb_drain", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
